barker_stream_gen: RTL and testbench
====================================

Name: barker_stream_gen

Overview:
- Synthesizable upstream source for the Barker correlator.
- Emits frames of the 11-chip Barker code 11'b11100010010, MSB first, on a 1-bit AXI-Stream master.
- Each chip is repeated OVERSAMPLE samples.
- Frames are golden, or corrupted under LFSR control. tuser flags the expected correlation result, and optional single-sample noise exercises the correlator's majority voting.

Parameters:
- OVERSAMPLE, 4, samples per chip (>=3).
- FRAME_COUNT, 128, frames per run; 0 = continuous until i_stop.
- NOISE_IDX, 1, sample index within each chip that is inverted when noise is enabled (< OVERSAMPLE).
- LFSR_SEED, 16'hACE1, LFSR reset/start value (non-zero).

Ports:
- i_clk  in  1  clock, all logic on rising edge.
- i_rst  in  1  synchronous, active-high reset.
- i_start  in  1  pulse; begins a run from IDLE.
- i_stop  in  1  pulse; end the run after the current frame.
- i_noise_en  in  1  enable single-sample inversion per chip.
- i_golden_only  in  1  force every frame golden.
- o_m_axis_tdata  out  1  sample value.
- o_m_axis_tvalid  out  1  sample valid.
- i_m_axis_tready  in  1  downstream ready.
- o_m_axis_tuser  out  1  1 = current frame is golden (expected correlator hit).
- o_m_axis_tlast  out  1  last sample of frame.
- o_busy  out  1  high while not IDLE.
- o_frame_cnt  out  16  frames completed in current run (wraps at 2^16).

Behaviour:
- Reset: all outputs 0, FSM=IDLE, counters 0, LFSR=LFSR_SEED. Reset wins over every other input in the same cycle. Mid-frame reset aborts immediately, with no partial-frame completion.
- FSM states and transitions:
  - IDLE -> LOAD on i_start.
  - LOAD (1 cycle): latch frame word, tuser; -> RUN.
  - RUN -> LOAD after handshake of tlast when more frames remain.
  - RUN -> IDLE after tlast handshake if the frame count is reached (FRAME_COUNT>0) or a stop is pending.
- Latency: first tvalid two cycles after i_start is sampled (IDLE->LOAD->RUN).
- Handshake:
  - Transfer = tvalid & tready.
  - tvalid high throughout RUN, never in IDLE/LOAD.
  - tdata/tuser/tlast held stable while tvalid & !tready.
  - tvalid never drops without a transfer.
  - Counters advance only on transfer.
- Counters:
  - Sample counter 0..OVERSAMPLE-1; chip index 10..0.
  - tlast = (chip==0 && sample==OVERSAMPLE-1).
  - Frame = 11*OVERSAMPLE transfers, e.g. 44 at default.
- tdata = word[chip] XOR (i_noise_en_latched && sample==NOISE_IDX). Noise enable is latched at LOAD, constant per frame.
- Frame selection at LOAD:
  - LFSR steps once: Fibonacci, taps 16,14,13,11.
  - Golden if i_golden_only or lfsr[0]==1, else word = GOLDEN ^ {lfsr[10:1],1'b1}, which is never golden.
  - tuser = golden flag, constant for the frame.
- Stop:
  - i_stop latched as stop_pending, cleared on entry to IDLE.
  - i_stop in IDLE is ignored.
  - i_stop and tlast handshake in the same cycle -> stop takes effect on that frame.
- i_start ignored outside IDLE.
- o_frame_cnt: +1 on each tlast transfer, cleared on the IDLE->LOAD transition, held in IDLE.
- LFSR is not reseeded between runs (only by reset).

Decomposition:
- Package barker_pkg:
  - BARKER_LEN=11.
  - GOLDEN_SEQ=11'b11100010010.
  - LFSR_TAPS.
  - fsm typedef enum {IDLE, LOAD, RUN}.
- Sub-module barker_lfsr16: step enable, seed, 16-bit state out.
- Main block holds the FSM, counters and output registers.

Test Plan:
- Reset, i_start, tready=1, i_golden_only=1, FRAME_COUNT=2 -> 88 transfers, tdata = 1111 1111 1111 0000 0000 0000 1111 0000 0000 1111 0000 per frame; tlast on transfers 44 and 88; tuser=1; o_frame_cnt=2; o_busy falls after transfer 88.
- Random tready (1-10 cycle toggles) -> data/tuser/tlast stable under stall; transfer sequence identical to the tready=1 run.
- i_noise_en=1, NOISE_IDX=1, golden -> chip 10 samples 1,0,1,1; chip 7 samples 0,1,0,0; majority decode still equals GOLDEN_SEQ.
- i_golden_only=0, seed 16'hACE1, 128 frames -> tuser matches a reference-model LFSR per frame; each tuser=0 frame decodes != GOLDEN_SEQ; both frame types occur.
- FRAME_COUNT=0, i_stop asserted at transfer 20 of frame 3 -> frame 3 completes (44 transfers), then IDLE, o_frame_cnt=3; i_start during RUN has no effect.
- i_rst at transfer 10 of frame 1 -> next cycle all outputs 0, IDLE; new i_start restarts at chip 10, sample 0, with LFSR=LFSR_SEED.

Source files
------------

// File: rtl/barker_pkg.sv
// barker_pkg: shared constants, types and the LFSR step function for the
// Barker-11 stream generator.
//   BARKER_LEN  - chips per frame
//   GOLDEN_SEQ  - Barker-11 code, bit 10 is the first chip on the wire
//   LFSR_TAPS   - feedback mask for the right-shifting Fibonacci LFSR
//   fsm_t       - generator control states
package barker_pkg;

    localparam int unsigned BARKER_LEN = 11;
    localparam logic [BARKER_LEN-1:0] GOLDEN_SEQ = 11'b11100010010;

    // Taps 16,14,13,11 of the polynomial map to state bits 0,2,3,5 when
    // the register shifts right and feedback enters at bit 15.
    localparam logic [15:0] LFSR_TAPS = 16'h002D;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2
    } fsm_t;

    function automatic logic [15:0] lfsr_step(input logic [15:0] s);
        logic fb;
        fb = ^(s & LFSR_TAPS);
        return {fb, s[15:1]};
    endfunction

endpackage

// File: rtl/barker_lfsr16.sv
// barker_lfsr16: 16-bit Fibonacci LFSR used to pick golden/corrupt frames.
//   i_clk   - clock
//   i_rst   - synchronous active-high reset, loads i_seed
//   i_step  - advance one step this cycle
//   i_seed  - reset value (must be non-zero)
//   o_state - current register contents
module barker_lfsr16
    import barker_pkg::*;
(
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_step,
    input  logic [15:0] i_seed,
    output logic [15:0] o_state
);

    logic [15:0] r_state;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= i_seed;
        end else if (i_step) begin
            r_state <= lfsr_step(r_state);
        end
    end

    assign o_state = r_state;

endmodule

// File: rtl/barker_stream_gen.sv
// barker_stream_gen: emits oversampled Barker-11 frames on a 1-bit
// AXI-Stream master. Frames are golden or LFSR-corrupted; tuser marks golden
// frames, and optional per-chip single-sample inversion is available.
//   i_clk, i_rst        - clock, synchronous active-high reset
//   i_start             - pulse, starts a run from IDLE
//   i_stop              - pulse, ends the run after the current frame
//   i_noise_en          - invert sample NOISE_IDX of every chip (latched per frame)
//   i_golden_only       - force every frame golden
//   o_m_axis_t*         - stream outputs (tdata/tvalid/tuser/tlast), i_m_axis_tready input
//   o_busy              - high while not IDLE
//   o_frame_cnt         - frames completed in the current run
module barker_stream_gen
    import barker_pkg::*;
#(
    parameter int unsigned OVERSAMPLE  = 4,
    parameter int unsigned FRAME_COUNT = 128,
    parameter int unsigned NOISE_IDX   = 1,
    parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_start,
    input  logic        i_stop,
    input  logic        i_noise_en,
    input  logic        i_golden_only,
    output logic        o_m_axis_tdata,
    output logic        o_m_axis_tvalid,
    input  logic        i_m_axis_tready,
    output logic        o_m_axis_tuser,
    output logic        o_m_axis_tlast,
    output logic        o_busy,
    output logic [15:0] o_frame_cnt
);

    localparam int unsigned SW = $clog2(OVERSAMPLE);
    localparam logic [SW-1:0] S_LAST      = SW'(OVERSAMPLE - 1);
    localparam logic [SW-1:0] S_NOISE     = SW'(NOISE_IDX);
    localparam logic [3:0]    CHIP_FIRST  = 4'(BARKER_LEN - 1);
    localparam logic [15:0]   FC          = 16'(FRAME_COUNT);
    localparam bit            COUNTED     = (FRAME_COUNT != 0);

    fsm_t r_state;
    fsm_t w_state_next;

    logic [BARKER_LEN-1:0] r_word;
    logic                  r_tuser;
    logic                  r_noise;
    logic                  r_stop_pending;
    logic [3:0]            r_chip;
    logic [SW-1:0]         r_sample;
    logic [15:0]           r_frame_cnt;

    logic                  w_run;
    logic                  w_xfer;
    logic                  w_last;
    logic                  w_last_xfer;
    logic                  w_done;
    logic [15:0]           w_lfsr;
    logic                  w_golden;
    logic [BARKER_LEN-1:0] w_word;
    logic                  w_unused_lfsr_hi;

    // The LFSR advances on the edge that enters LOAD, so during LOAD its
    // output is already the stepped value used to pick this frame.
    barker_lfsr16 u_lfsr (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_step  (w_state_next == LOAD),
        .i_seed  (LFSR_SEED),
        .o_state (w_lfsr)
    );

    assign w_unused_lfsr_hi = ^w_lfsr[15:11];

    assign w_golden = i_golden_only | w_lfsr[0];
    // Forcing bit 0 of the mask to 1 guarantees a corrupt frame differs from golden.
    assign w_word   = w_golden ? GOLDEN_SEQ
                               : (GOLDEN_SEQ ^ {w_lfsr[10:1], 1'b1});

    assign w_run       = (r_state == RUN);
    assign w_xfer      = w_run & i_m_axis_tready;
    assign w_last      = (r_chip == 4'd0) && (r_sample == S_LAST);
    assign w_last_xfer = w_xfer & w_last;
    // A stop arriving with the tlast handshake still ends the run on this frame.
    assign w_done      = (COUNTED && ((r_frame_cnt + 16'd1) == FC))
                         || r_stop_pending || i_stop;

    // ---------------- state register ----------------
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ---------------- next-state logic ----------------
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (i_start) w_state_next = LOAD;
            LOAD:    w_state_next = RUN;
            RUN:     if (w_last_xfer) w_state_next = w_done ? IDLE : LOAD;
            default: w_state_next = IDLE;
        endcase
    end

    // ---------------- outputs ----------------
    always_comb begin
        o_m_axis_tvalid = w_run;
        o_m_axis_tdata  = w_run & (r_word[r_chip] ^ (r_noise && (r_sample == S_NOISE)));
        o_m_axis_tlast  = w_run & w_last;
        o_m_axis_tuser  = r_tuser;
        o_busy          = (r_state != IDLE);
        o_frame_cnt     = r_frame_cnt;
    end

    // ---------------- datapath ----------------
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_word         <= '0;
            r_tuser        <= 1'b0;
            r_noise        <= 1'b0;
            r_stop_pending <= 1'b0;
            r_chip         <= '0;
            r_sample       <= '0;
            r_frame_cnt    <= '0;
        end else begin
            if (w_state_next == IDLE) begin
                r_stop_pending <= 1'b0;
            end else if ((r_state != IDLE) && i_stop) begin
                r_stop_pending <= 1'b1;
            end

            if ((r_state == IDLE) && i_start) begin
                r_frame_cnt <= '0;
            end

            if (r_state == LOAD) begin
                r_word   <= w_word;
                r_tuser  <= w_golden;
                r_noise  <= i_noise_en;
                r_chip   <= CHIP_FIRST;
                r_sample <= '0;
            end

            if (w_xfer) begin
                if (r_sample == S_LAST) begin
                    r_sample <= '0;
                    if (r_chip != 4'd0) begin
                        r_chip <= r_chip - 4'd1;
                    end
                end else begin
                    r_sample <= r_sample + SW'(1);
                end
            end

            if (w_last_xfer) begin
                r_frame_cnt <= r_frame_cnt + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_barker_stream_gen.sv
module tb_barker_stream_gen;
    import barker_pkg::*;

    localparam int unsigned OS    = 4;
    localparam int unsigned FCNT  = 3;
    localparam int unsigned NIDX  = 1;
    localparam logic [15:0] SEED  = 16'hACE1;

    logic        clk = 1'b0;
    logic        i_rst = 1'b1;
    logic        i_start = 1'b0;
    logic        i_stop = 1'b0;
    logic        i_noise_en = 1'b0;
    logic        i_golden_only = 1'b0;
    logic        tready = 1'b1;
    logic        tdata, tvalid, tuser, tlast, busy;
    logic [15:0] frame_cnt;

    always #5 clk = ~clk;

    barker_stream_gen #(
        .OVERSAMPLE  (OS),
        .FRAME_COUNT (FCNT),
        .NOISE_IDX   (NIDX),
        .LFSR_SEED   (SEED)
    ) dut (
        .i_clk           (clk),
        .i_rst           (i_rst),
        .i_start         (i_start),
        .i_stop          (i_stop),
        .i_noise_en      (i_noise_en),
        .i_golden_only   (i_golden_only),
        .o_m_axis_tdata  (tdata),
        .o_m_axis_tvalid (tvalid),
        .i_m_axis_tready (tready),
        .o_m_axis_tuser  (tuser),
        .o_m_axis_tlast  (tlast),
        .o_busy          (busy),
        .o_frame_cnt     (frame_cnt)
    );

    typedef struct packed {
        logic d;
        logic u;
        logic l;
    } exp_t;

    exp_t        sb[$];
    int          n_vec = 0;
    int          n_fail = 0;
    int          n_xfer = 0;
    int          n_gold_seen = 0;
    int          n_bad_seen = 0;
    logic [15:0] m_lfsr = SEED;
    bit          rnd_rdy = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: one LFSR step per frame, then build the expected samples.
    task automatic push_frame(input logic gold_only, input logic noise);
        logic [10:0] gseq;
        logic [10:0] w;
        logic        g;
        logic        fb;
        exp_t        e;
        gseq   = 11'b11100010010;
        fb     = m_lfsr[0] ^ m_lfsr[2] ^ m_lfsr[3] ^ m_lfsr[5];
        m_lfsr = {fb, m_lfsr[15:1]};
        g      = gold_only | m_lfsr[0];
        w      = g ? gseq : (gseq ^ {m_lfsr[10:1], 1'b1});
        for (int c = 10; c >= 0; c--) begin
            for (int s = 0; s < int'(OS); s++) begin
                e.d = w[c] ^ (noise && (s == int'(NIDX)));
                e.u = g;
                e.l = (c == 0) && (s == int'(OS) - 1);
                sb.push_back(e);
            end
        end
    endtask

    // ---------------- ready driver ----------------
    int rdy_cnt = 0;
    always @(posedge clk) begin
        #1;
        if (rnd_rdy) begin
            if (rdy_cnt <= 0) begin
                tready  = ~tready;
                rdy_cnt = int'($urandom_range(1, 10));
            end
            rdy_cnt--;
        end else begin
            tready = 1'b1;
        end
    end

    // ---------------- monitor / scoreboard ----------------
    logic        stall_prev = 1'b0;
    logic        h_d, h_u, h_l;
    int          mon_pos = 0;
    int          mon_ones = 0;
    logic [10:0] rx_word = '0;

    always @(negedge clk) begin
        exp_t e;
        if (i_rst) begin
            stall_prev = 1'b0;
            mon_pos    = 0;
            mon_ones   = 0;
            rx_word    = '0;
        end else begin
            if (stall_prev) begin
                chk("hold_tvalid", {31'd0, tvalid}, 32'd1);
                chk("hold_data", {29'd0, tdata, tuser, tlast}, {29'd0, h_d, h_u, h_l});
            end
            if (tvalid && tready) begin
                if (sb.size() == 0) begin
                    chk("unexpected_xfer", 32'd1, 32'd0);
                end else begin
                    e = sb.pop_front();
                    chk("xfer", {29'd0, tdata, tuser, tlast}, {29'd0, e.d, e.u, e.l});
                end
                n_xfer++;
                mon_ones += int'(tdata);
                if (mon_pos == int'(OS) - 1) begin
                    rx_word  = {rx_word[9:0], (mon_ones > 2)};
                    mon_ones = 0;
                    mon_pos  = 0;
                end else begin
                    mon_pos++;
                end
                if (tlast) begin
                    chk("decode_vs_tuser", {31'd0, (rx_word == GOLDEN_SEQ)}, {31'd0, tuser});
                    if (tuser) n_gold_seen++;
                    else       n_bad_seen++;
                end
            end
            stall_prev = tvalid && !tready;
            h_d = tdata;
            h_u = tuser;
            h_l = tlast;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic start_run(input bit check_latency);
        @(posedge clk); #1;
        n_xfer  = 0;
        i_start = 1'b1;
        @(posedge clk); #1;
        i_start = 1'b0;
        if (check_latency) begin
            chk("load_tvalid", {31'd0, tvalid}, 32'd0);
            chk("load_busy", {31'd0, busy}, 32'd1);
        end
        @(posedge clk); #1;
        if (check_latency) begin
            chk("first_tvalid", {31'd0, tvalid}, 32'd1);
        end
    endtask

    task automatic wait_xfer(input int target, input int budget);
        int k;
        k = 0;
        while (n_xfer < target && k < budget) begin
            @(posedge clk);
            k++;
        end
        if (n_xfer < target) chk("wait_xfer_timeout", n_xfer, target);
    endtask

    task automatic wait_idle(input string name, input logic [15:0] exp_cnt, input int budget);
        int k;
        k = 0;
        @(posedge clk); #1;
        while (busy && k < budget) begin
            @(posedge clk); #1;
            k++;
        end
        chk({name, "_idle"}, {31'd0, busy}, 32'd0);
        chk({name, "_frame_cnt"}, {16'd0, frame_cnt}, {16'd0, exp_cnt});
        @(negedge clk);
        chk({name, "_sb_empty"}, sb.size(), 32'd0);
    endtask

    task automatic pulse_stop;
        i_stop = 1'b1;
        @(posedge clk); #1;
        i_stop = 1'b0;
    endtask

    // ---------------- main sequence ----------------
    initial begin
        i_rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_tvalid", {31'd0, tvalid}, 32'd0);
        chk("rst_tdata", {31'd0, tdata}, 32'd0);
        chk("rst_tuser", {31'd0, tuser}, 32'd0);
        chk("rst_tlast", {31'd0, tlast}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_frame_cnt", {16'd0, frame_cnt}, 32'd0);
        i_rst = 1'b0;

        // Stop in IDLE must be ignored; then a full golden run.
        @(posedge clk); #1;
        pulse_stop();
        i_golden_only = 1'b1;
        for (int f = 0; f < int'(FCNT); f++) push_frame(1'b1, 1'b0);
        start_run(1'b1);
        wait_idle("golden", 16'd3, 500);
        chk("golden_xfers", n_xfer, 32'd132);

        // Golden frames with single-sample noise.
        i_noise_en = 1'b1;
        for (int f = 0; f < int'(FCNT); f++) push_frame(1'b1, 1'b1);
        start_run(1'b1);
        wait_idle("noise", 16'd3, 500);
        i_noise_en = 1'b0;

        // LFSR-selected frames under random backpressure, 129 frames total.
        i_golden_only = 1'b0;
        rnd_rdy = 1'b1;
        for (int r = 0; r < 43; r++) begin
            for (int f = 0; f < int'(FCNT); f++) push_frame(1'b0, 1'b0);
            start_run(1'b0);
            wait_idle("random", 16'd3, 2000);
        end
        rnd_rdy = 1'b0;
        repeat (2) @(posedge clk);
        chk("golden_frames_seen", {31'd0, (n_gold_seen > 0)}, 32'd1);
        chk("corrupt_frames_seen", {31'd0, (n_bad_seen > 0)}, 32'd1);

        // Stop mid frame 2; a start during RUN must not be remembered.
        for (int f = 0; f < 2; f++) push_frame(1'b0, 1'b0);
        start_run(1'b1);
        wait_xfer(63, 300);
        #1;
        pulse_stop();
        i_start = 1'b1;
        @(posedge clk); #1;
        i_start = 1'b0;
        wait_idle("stop", 16'd2, 500);
        repeat (3) @(posedge clk);
        #1;
        chk("start_in_run_ignored", {31'd0, busy}, 32'd0);

        // Stop coincident with the tlast handshake of frame 1.
        push_frame(1'b0, 1'b0);
        start_run(1'b0);
        wait_xfer(43, 300);
        #1;
        pulse_stop();
        wait_idle("stop_at_tlast", 16'd1, 500);

        // Reset at transfer 10 of frame 1, then restart from the seed.
        for (int f = 0; f < int'(FCNT); f++) push_frame(1'b0, 1'b0);
        start_run(1'b0);
        wait_xfer(10, 300);
        #1;
        i_rst = 1'b1;
        @(posedge clk); #1;
        chk("midrst_tvalid", {31'd0, tvalid}, 32'd0);
        chk("midrst_tdata", {31'd0, tdata}, 32'd0);
        chk("midrst_tuser", {31'd0, tuser}, 32'd0);
        chk("midrst_tlast", {31'd0, tlast}, 32'd0);
        chk("midrst_busy", {31'd0, busy}, 32'd0);
        chk("midrst_frame_cnt", {16'd0, frame_cnt}, 32'd0);
        sb.delete();
        m_lfsr = SEED;
        i_rst  = 1'b0;
        for (int f = 0; f < int'(FCNT); f++) push_frame(1'b0, 1'b0);
        start_run(1'b1);
        wait_idle("after_rst", 16'd3, 500);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
